seg_scan: RTL

//   Multi-digit time-multiplexed display scanner: sits directly upstream of the
//   seg BCD-to-7-segment decoder. Latches a packed BCD word on a load strobe and

---
 rtl/seg_scan.sv | 79 +++++++
 1 files changed

// File: rtl/seg_scan.sv
// Time-multiplexed BCD display scanner feeding a 7-segment decoder.
// Latches a packed BCD word and walks one active-low anode per DIV-clock slot.
module seg_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       value,
  output logic [3:0]                digit_bcd,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] slot
);

  localparam int unsigned SW = $clog2(DIGITS);
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned VW = 4 * DIGITS;

  logic [VW-1:0]     shadow;
  logic [PW-1:0]     presc;
  logic [SW-1:0]     idx;
  logic              tick_c;
  logic [DIGITS-1:0] nz_c;
  logic              blank_c;
  logic [3:0]        cur_c;

  assign tick_c = (presc == PW'(DIV - 1));

  // Slot prescaler and scan index; load never disturbs the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (tick_c) begin
        idx <= (idx == SW'(DIGITS - 1)) ? '0 : idx + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= value;
    end
  end

  // nz_c[k] is set when any digit at position k or above is nonzero.
  always_comb begin
    nz_c = '0;
    nz_c[DIGITS-1] = |shadow[VW-1 -: 4];
    for (int k = int'(DIGITS) - 2; k >= 0; k--) begin
      nz_c[k] = nz_c[k+1] | (|shadow[4*k +: 4]);
    end
  end

  always_comb begin
    cur_c   = shadow[{idx, 2'b00} +: 4];
    blank_c = (BLANK_LZ != 0) && (idx != '0) && !nz_c[idx];
  end

  // Registered display outputs; a blanked slot keeps its time but stays dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_bcd <= '0;
      an        <= '1;
      slot      <= '0;
    end else begin
      digit_bcd <= cur_c;
      slot      <= idx;
      an        <= blank_c ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule
